// File: rtl/fx_accum_dump_if.sv
// Sample-in / dump-out bundle of the integrate-and-dump stage.
// The upstream side (master) drives samples and the clear request,
// the accumulator (slave) returns the registered dump outputs.
interface fx_accum_dump_if #(
   parameter int IN_W  = 13,
   parameter int OUT_W = 16
);
   logic                    i_valid;
   logic signed [IN_W-1:0]  i_data;
   logic                    i_clear;
   logic                    o_valid;
   logic [OUT_W-1:0]        o_data;
   logic                    o_sat;
   logic                    o_ovf;

   modport master (
      output i_valid, i_data, i_clear,
      input  o_valid, o_data, o_sat, o_ovf
   );

   modport slave (
      input  i_valid, i_data, i_clear,
      output o_valid, o_data, o_sat, o_ovf
   );
endinterface

// File: rtl/fx_accum_dump.sv
// Integrate-and-dump: sums LEN valid samples at full precision, then
// pushes each block total through a dump / round-half-up / saturate
// pipeline. A dump leaves o_valid three clocks after its last sample.
module fx_accum_dump #(
   parameter int IN_W     = 13,
   parameter int IN_FRAC  = 8,
   parameter int OUT_W    = 16,
   parameter int OUT_FRAC = 4,
   parameter int LEN      = 16,
   parameter int ACC_W    = 24
) (
   input  logic           clk,
   input  logic           rst,
   fx_accum_dump_if.slave bus
);
   localparam int SH    = IN_FRAC - OUT_FRAC;
   localparam int CNT_W = $clog2(LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
   // Clamp bounds expressed in the widened quantizer domain.
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(OUT_W-1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = -(ACC_W+1)'(2**(OUT_W-1));

   logic signed [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0]        r_cnt;
   logic signed [ACC_W-1:0] r_s1;
   logic                    r_s1_v;
   logic signed [ACC_W:0]   r_s2;
   logic                    r_s2_v;
   logic [OUT_W-1:0]        r_o_data;
   logic                    r_o_valid;
   logic                    r_o_sat;
   logic                    r_o_ovf;

   logic signed [ACC_W-1:0] w_data_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic                    w_last;
   logic                    w_dump;
   logic signed [ACC_W:0]   w_s1_ext;
   logic signed [ACC_W:0]   w_q;
   logic                    w_hi;
   logic                    w_lo;
   logic [OUT_W-1:0]        w_o_next;

   assign w_data_ext = {{(ACC_W-IN_W){bus.i_data[IN_W-1]}}, bus.i_data};
   assign w_sum      = r_acc + w_data_ext;
   assign w_last     = bus.i_valid && (r_cnt == CNT_LAST);
   // A clear in the closing cycle aborts the block instead of dumping it.
   assign w_dump     = w_last && !bus.i_clear;

   // Accumulator and sample counter; clear restarts the block, possibly with this sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (bus.i_clear) begin
         r_acc <= bus.i_valid ? w_data_ext : '0;
         r_cnt <= bus.i_valid ? CNT_W'(1) : '0;
      end else if (w_last) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (bus.i_valid) begin
         r_acc <= w_sum;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // S1: capture the completed block total on the closing sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1   <= '0;
         r_s1_v <= 1'b0;
      end else begin
         r_s1_v <= w_dump;
         if (w_dump) begin
            r_s1 <= w_sum;
         end
      end
   end

   // One guard bit keeps the rounding add from wrapping.
   assign w_s1_ext = {r_s1[ACC_W-1], r_s1};

   generate
      if (SH > 0) begin : g_round
         localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(2**(SH-1));
         assign w_q = (w_s1_ext + HALF) >>> SH;
      end else begin : g_pass
         assign w_q = w_s1_ext;
      end
   endgenerate

   // S2: register the rounded value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2   <= '0;
         r_s2_v <= 1'b0;
      end else begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2 <= w_q;
         end
      end
   end

   assign w_hi = (r_s2 > SAT_MAX);
   assign w_lo = (r_s2 < SAT_MIN);

   // Clamp to the output word range, else keep the low OUT_W bits.
   always_comb begin
      w_o_next = r_s2[OUT_W-1:0];
      if (w_hi) begin
         w_o_next = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (w_lo) begin
         w_o_next = {1'b1, {(OUT_W-1){1'b0}}};
      end
   end

   // S3: output register, dump strobe and sticky overflow (set beats clear).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_o_valid <= 1'b0;
         r_o_data  <= '0;
         r_o_sat   <= 1'b0;
         r_o_ovf   <= 1'b0;
      end else begin
         r_o_valid <= r_s2_v;
         if (r_s2_v) begin
            r_o_data <= w_o_next;
            r_o_sat  <= w_hi || w_lo;
         end
         if (r_s2_v && (w_hi || w_lo)) begin
            r_o_ovf <= 1'b1;
         end else if (bus.i_clear) begin
            r_o_ovf <= 1'b0;
         end
      end
   end

   assign bus.o_valid = r_o_valid;
   assign bus.o_data  = r_o_data;
   assign bus.o_sat   = r_o_sat;
   assign bus.o_ovf   = r_o_ovf;
endmodule

// File: tb/tb_fx_accum_dump.sv
// Directed bench for fx_accum_dump. Three instances share one stimulus:
// u0 LEN=4 defaults, u1 LEN=4 OUT_W=10, u2 LEN=16 defaults. A monitor
// logs every dump; each test picks the dumps of the instance it targets.
module tb_fx_accum_dump;
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              tb_valid = 1'b0;
   logic signed [12:0] tb_data = '0;
   logic              tb_clear = 1'b0;
   int                cyc = 0;
   int                n_checks = 0;
   int                n_fail = 0;
   int                t_first;
   int                t_last;
   int                t1;
   int                t2;

   typedef struct {
      int          inst;
      logic [15:0] d;
      bit          s;
      int          cyc;
   } dump_t;

   dump_t q[$];
   dump_t sel[$];

   fx_accum_dump_if #(.IN_W(13), .OUT_W(16)) bus0 ();
   fx_accum_dump_if #(.IN_W(13), .OUT_W(10)) bus1 ();
   fx_accum_dump_if #(.IN_W(13), .OUT_W(16)) bus2 ();

   assign bus0.i_valid = tb_valid;
   assign bus0.i_data  = tb_data;
   assign bus0.i_clear = tb_clear;
   assign bus1.i_valid = tb_valid;
   assign bus1.i_data  = tb_data;
   assign bus1.i_clear = tb_clear;
   assign bus2.i_valid = tb_valid;
   assign bus2.i_data  = tb_data;
   assign bus2.i_clear = tb_clear;

   fx_accum_dump #(.IN_W(13), .IN_FRAC(8), .OUT_W(16), .OUT_FRAC(4), .LEN(4), .ACC_W(24))
      u0 (.clk(clk), .rst(rst), .bus(bus0));
   fx_accum_dump #(.IN_W(13), .IN_FRAC(8), .OUT_W(10), .OUT_FRAC(4), .LEN(4), .ACC_W(24))
      u1 (.clk(clk), .rst(rst), .bus(bus1));
   fx_accum_dump #(.IN_W(13), .IN_FRAC(8), .OUT_W(16), .OUT_FRAC(4), .LEN(16), .ACC_W(24))
      u2 (.clk(clk), .rst(rst), .bus(bus2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every dump, one line per transaction.
   always @(negedge clk) begin
      if (bus0.o_valid) begin
         q.push_back('{0, bus0.o_data, bus0.o_sat, cyc});
         $display("dump inst=0 data=0x%04h sat=%0b cyc=%0d", bus0.o_data, bus0.o_sat, cyc);
      end
      if (bus1.o_valid) begin
         q.push_back('{1, 16'(bus1.o_data), bus1.o_sat, cyc});
         $display("dump inst=1 data=0x%03h sat=%0b cyc=%0d", bus1.o_data, bus1.o_sat, cyc);
      end
      if (bus2.o_valid) begin
         q.push_back('{2, bus2.o_data, bus2.o_sat, cyc});
         $display("dump inst=2 data=0x%04h sat=%0b cyc=%0d", bus2.o_data, bus2.o_sat, cyc);
      end
   end

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // One clock with the given inputs; returns 1 time unit after the edge.
   task automatic step(input bit v, input int d, input bit c);
      tb_valid = v;
      tb_data  = 13'(d);
      tb_clear = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int n, input int d);
      for (int i = 0; i < n; i++) begin
         step(1'b1, d, 1'b0);
         if (i == 0) t_first = cyc;
         t_last = cyc;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
   endtask

   task automatic grab(input int inst);
      sel.delete();
      foreach (q[i]) if (q[i].inst == inst) sel.push_back(q[i]);
      q.delete();
   endtask

   task automatic chk_dump(input string tag, input int i, input logic [15:0] d,
                           input bit s, input int c);
      if (i < sel.size()) begin
         check_val({tag, "_data"}, sel[i].d, d);
         check_val({tag, "_sat"}, sel[i].s, s);
         check_val({tag, "_cyc"}, sel[i].cyc, c);
      end else begin
         check_val({tag, "_present"}, sel.size(), i + 1);
      end
   endtask

   initial begin
      // Reset values
      idle(3);
      check_val("rst_valid", bus0.o_valid, 0);
      check_val("rst_data", bus0.o_data, 0);
      check_val("rst_sat", bus0.o_sat, 0);
      check_val("rst_ovf", bus0.o_ovf, 0);
      rst = 1'b0;
      idle(2);

      // Rounding: 4x26 -> 7, 4x-26 -> -6
      q.delete();
      send(4, 26);
      idle(6);
      grab(0);
      check_val("rnd_pos_count", sel.size(), 1);
      chk_dump("rnd_pos", 0, 16'h0007, 1'b0, t_last + 2);
      send(4, -26);
      idle(6);
      grab(0);
      check_val("rnd_neg_count", sel.size(), 1);
      chk_dump("rnd_neg", 0, 16'hFFFA, 1'b0, t_last + 2);

      // Async reset with a dump in flight: outputs clear at once, dump lost
      send(4, 26);
      idle(1);
      #2 rst = 1'b1;
      #1;
      check_val("arst_valid", bus0.o_valid, 0);
      check_val("arst_data", bus0.o_data, 0);
      check_val("arst_sat", bus0.o_sat, 0);
      check_val("arst_ovf", bus0.o_ovf, 0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      idle(50);
      grab(0);
      check_val("idle_count0", sel.size(), 0);

      // Saturation on the 10-bit instance
      q.delete();
      send(4, 13'h0FFF);
      idle(6);
      grab(1);
      chk_dump("sat_hi", 0, 16'h01FF, 1'b1, t_last + 2);
      check_val("sat_hi_ovf", bus1.o_ovf, 1);
      send(4, -4096);
      idle(6);
      grab(1);
      chk_dump("sat_lo", 0, 16'h0200, 1'b1, t_last + 2);
      send(4, 1);
      idle(6);
      grab(1);
      chk_dump("sat_none", 0, 16'h0000, 1'b0, t_last + 2);
      check_val("sat_ovf_sticky", bus1.o_ovf, 1);

      // Gapped input: 16 x4 with idle gaps of 2, 0, 3
      q.delete();
      send(1, 16); idle(2);
      send(1, 16);
      send(1, 16); idle(3);
      send(1, 16);
      idle(6);
      grab(0);
      check_val("gap_count", sel.size(), 1);
      chk_dump("gap", 0, 16'h0004, 1'b0, t_last + 2);
      send(4, 26);
      idle(6);
      grab(0);
      chk_dump("gap_next", 0, 16'h0007, 1'b0, t_last + 2);

      // Clear aborts a partial block and clears the sticky flag
      q.delete();
      send(3, 100);
      step(1'b1, 16, 1'b1);
      check_val("clr_ovf", bus1.o_ovf, 0);
      send(3, 16);
      idle(6);
      grab(0);
      check_val("clr_count", sel.size(), 1);
      chk_dump("clr", 0, 16'h0004, 1'b0, t_last + 2);

      // Clear right after a block end leaves the in-flight dump intact
      q.delete();
      send(4, 26);
      t1 = t_last;
      step(1'b1, 16, 1'b1);
      send(3, 16);
      t2 = t_last;
      idle(6);
      grab(0);
      check_val("clr_fl_count", sel.size(), 2);
      chk_dump("clr_fl_old", 0, 16'h0007, 1'b0, t1 + 2);
      chk_dump("clr_fl_new", 1, 16'h0004, 1'b0, t2 + 2);

      // Continuous stream on LEN=16: four dumps of 16.0, 16 cycles apart
      #2 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      q.delete();
      send(64, 256);
      idle(6);
      grab(2);
      check_val("cont_count", sel.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk_dump($sformatf("cont%0d", i), i, 16'h0100, 1'b0, t_first + 17 + 16 * i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
